dual_issue_ctrl: RTL and testbench
==================================

Name: dual_issue_ctrl

Overview:
Issue controller for the dual-issue fetch stage. Each cycle it examines the instruction pair InstrA/InstrB at the current PC and decides whether to issue both, only A, or neither. It drives the fetch stage's PCSrc (hold) and IncrSrc (+4/+8) selects. A load-latency scoreboard and a branch-wait state machine provide the sequential hazard tracking.

Parameters:
DATA_WIDTH, 32, instruction width
LOAD_LAT, 3, cycles from load issue until its rd can be read (>=1)
CNT_WIDTH, 32, width of the performance counters

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
InstrA  input  DATA_WIDTH  instruction at PC
InstrB  input  DATA_WIDTH  instruction at PC+4
stall_ext  input  1  downstream stall; blocks all issue
br_resolved  input  1  execute stage has resolved the outstanding control-flow instruction
IssueA  output  1  lane A issues this cycle
IssueB  output  1  lane B issues this cycle
PCSrc  output  1  0 = take PCincr, 1 = hold PC
IncrSrc  output  1  0 = +4, 1 = +8
dual_cnt  output  CNT_WIDTH  number of cycles with a dual issue
single_cnt  output  CNT_WIDTH  number of cycles with a single issue

Behaviour:
- Decode fields: opcode[6:0], rd[11:7], rs1[19:15], rs2[24:20].
- An instruction writes rd if its opcode is OP 0110011, OP-IMM 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111 or JALR 1100111, and rd != 0.
- Reads rs1: every opcode except LUI, AUIPC and JAL. Reads rs2: OP, STORE 0100011, BRANCH 1100011. A read of x0 never creates a hazard.
- Control-flow instructions: BRANCH, JAL, JALR. Memory instructions: LOAD, STORE.
- Scoreboard: one counter per x1..x31, width clog2(LOAD_LAT+1). A register is busy while its counter != 0.
  - Issuing a load with rd != 0 sets sb[rd] = LOAD_LAT.
  - Every other nonzero counter decrements by 1 each cycle, including during stalls and in WAIT_BR.
  - If a set and a decrement hit the same register in the same cycle, the set wins.
  - Timing: load issued at cycle t; a dependent instruction may issue at cycle t+LOAD_LAT.
- FSM states RUN and WAIT_BR.
  - RUN -> WAIT_BR when an issued lane holds a control-flow instruction.
  - WAIT_BR -> RUN on the edge where br_resolved=1.
  - br_resolved is ignored while in RUN.
  - No issue occurs in WAIT_BR, including the cycle in which br_resolved is asserted.
- IssueA = state==RUN & !stall_ext & !rst & none of A's read sources busy & A's rd (if written) not busy.
- IssueB = IssueA, and all of the following hold:
  - A is not control-flow.
  - A and B are not both memory instructions.
  - B reads no register equal to A's written rd.
  - B's rd (if written) differs from A's written rd.
  - B's sources and rd are not busy.
  - The scoreboard is checked against its pre-issue state; a load in A blocks B via the pairing rules above.
- Selects (IssueA, IssueB, PCSrc, IncrSrc are combinational from state, scoreboard, instructions and stall_ext):
  - IssueA & IssueB: PCSrc=0, IncrSrc=1.
  - IssueA only: PCSrc=0, IncrSrc=0.
  - No issue: PCSrc=1, IncrSrc=0.
- Counters: dual_cnt increments on dual issue, single_cnt on single issue. Both wrap modulo 2^CNT_WIDTH.
- Reset, on the clock edge with rst=1:
  - state=RUN, all scoreboard counters=0, both perf counters=0.
  - While rst=1: IssueA=IssueB=0, PCSrc=1, IncrSrc=0.
  - Reset mid-WAIT_BR or with loads pending discards all tracking.

Test Plan:
- Independent pair: A=0x00100093 (addi x1,x0,1), B=0x00200113 (addi x2,x0,2) -> IssueA=IssueB=1, IncrSrc=1, PCSrc=0, dual_cnt 0->1.
- Intra-pair RAW: A=0x00100093, B=0x002081B3 (add x3,x1,x2) -> IssueA=1, IssueB=0, IncrSrc=0, single_cnt increments.
- Load-use, LOAD_LAT=3:
  - Cycle t: issue A=0x0000A283 (lw x5,0(x1)) alone.
  - Cycles t+1, t+2: A=0x00528333 (add x6,x5,x5) -> IssueA=0, PCSrc=1.
  - Cycle t+3: IssueA=1.
- Branch wait:
  - Issue A=0x00208463 (beq x1,x2,8) -> IssueB=0, state WAIT_BR.
  - PCSrc=1 for 4 cycles with br_resolved=0, then br_resolved=1 -> issue resumes the following cycle.
- Dual memory: A=0x0000A283 (lw x5), B=0x0060A023 (sw x6,0(x1)) -> single issue only. Assert stall_ext with the same pair -> IssueA=0, PCSrc=1, and sb[x5] keeps decrementing.
- Reset: rst=1 in WAIT_BR with sb[x5]=2 -> next cycle with rst=0 and A=0x00528333, the instruction issues immediately and both counters read 0.

Source files
------------

// File: rtl/dual_issue_if.sv
// Bundle between the dual-issue fetch stage and its issue controller: the
// instruction pair, the stall and branch-resolve inputs, and the issue decision.
interface dual_issue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic [DATA_WIDTH-1:0] InstrA;
    logic [DATA_WIDTH-1:0] InstrB;
    logic                  stall_ext;
    logic                  br_resolved;
    logic                  IssueA;
    logic                  IssueB;
    logic                  PCSrc;
    logic                  IncrSrc;
    logic [CNT_WIDTH-1:0]  dual_cnt;
    logic [CNT_WIDTH-1:0]  single_cnt;

    modport master (
        output InstrA, InstrB, stall_ext, br_resolved,
        input  IssueA, IssueB, PCSrc, IncrSrc, dual_cnt, single_cnt
    );

    modport slave (
        input  InstrA, InstrB, stall_ext, br_resolved,
        output IssueA, IssueB, PCSrc, IncrSrc, dual_cnt, single_cnt
    );
endinterface

// File: rtl/dual_issue_ctrl.sv
// Dual-issue controller: decides per cycle whether to issue both, only A, or neither,
// using a load-latency scoreboard and a branch-wait state machine.
module dual_issue_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int LOAD_LAT   = 3,
    parameter int CNT_WIDTH  = 32
) (
    input  logic         clk,
    input  logic         rst,
    dual_issue_if.slave  bus
);
    localparam int SBW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
    // Counter holds the cycles still blocked after the issue cycle, so a dependent
    // instruction issues exactly LOAD_LAT cycles after the load.
    localparam logic [SBW-1:0] SB_SET = SBW'(LOAD_LAT - 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] WAIT_BR = 1'b1;

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
            default:                      writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL: reads_rs1 = 1'b0;
            default:                     reads_rs1 = 1'b1;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        case (op)
            OPC_OP, OPC_STORE, OPC_BRANCH: reads_rs2 = 1'b1;
            default:                       reads_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic is_cf(input logic [6:0] op);
        is_cf = (op == OPC_BRANCH) || (op == OPC_JAL) || (op == OPC_JALR);
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        is_mem = (op == OPC_LOAD) || (op == OPC_STORE);
    endfunction

    logic [0:0]           state_q, state_d;
    logic [SBW-1:0]       sb_q [1:31];
    logic [SBW-1:0]       sb_d [1:31];
    logic [CNT_WIDTH-1:0] dual_q, dual_d, single_q, single_d;

    logic [6:0] op_a_s, op_b_s;
    logic [4:0] rd_a_s, rs1_a_s, rs2_a_s, rd_b_s, rs1_b_s, rs2_b_s;
    logic       wa_s, wb_s, hazard_a_s, hazard_b_s, pair_ok_s;
    logic       issue_a_s, issue_b_s, ld_a_s, ld_b_s;
    logic [31:0] busy_s;

    assign op_a_s  = bus.InstrA[6:0];
    assign rd_a_s  = bus.InstrA[11:7];
    assign rs1_a_s = bus.InstrA[19:15];
    assign rs2_a_s = bus.InstrA[24:20];
    assign op_b_s  = bus.InstrB[6:0];
    assign rd_b_s  = bus.InstrB[11:7];
    assign rs1_b_s = bus.InstrB[19:15];
    assign rs2_b_s = bus.InstrB[24:20];

    assign wa_s = writes_rd(op_a_s) && (rd_a_s != 5'd0);
    assign wb_s = writes_rd(op_b_s) && (rd_b_s != 5'd0);

    // Busy vector from the pre-issue scoreboard; x0 is never busy.
    always_comb begin
        busy_s    = 32'd0;
        busy_s[0] = 1'b0;
        for (int i = 1; i < 32; i++) begin
            busy_s[i] = (sb_q[i] != '0);
        end
    end

    assign hazard_a_s = (reads_rs1(op_a_s) && busy_s[rs1_a_s]) ||
                        (reads_rs2(op_a_s) && busy_s[rs2_a_s]) ||
                        (wa_s && busy_s[rd_a_s]);
    assign hazard_b_s = (reads_rs1(op_b_s) && busy_s[rs1_b_s]) ||
                        (reads_rs2(op_b_s) && busy_s[rs2_b_s]) ||
                        (wb_s && busy_s[rd_b_s]);

    assign pair_ok_s = !is_cf(op_a_s) &&
                       !(is_mem(op_a_s) && is_mem(op_b_s)) &&
                       !(wa_s && reads_rs1(op_b_s) && (rs1_b_s == rd_a_s)) &&
                       !(wa_s && reads_rs2(op_b_s) && (rs2_b_s == rd_a_s)) &&
                       !(wa_s && wb_s && (rd_b_s == rd_a_s));

    assign issue_a_s = (state_q == RUN) && !bus.stall_ext && !rst && !hazard_a_s;
    assign issue_b_s = issue_a_s && pair_ok_s && !hazard_b_s;
    assign ld_a_s    = issue_a_s && (op_a_s == OPC_LOAD) && (rd_a_s != 5'd0);
    assign ld_b_s    = issue_b_s && (op_b_s == OPC_LOAD) && (rd_b_s != 5'd0);

    assign bus.IssueA     = issue_a_s;
    assign bus.IssueB     = issue_b_s;
    assign bus.PCSrc      = !issue_a_s;
    assign bus.IncrSrc    = issue_b_s;
    assign bus.dual_cnt   = dual_q;
    assign bus.single_cnt = single_q;

    // Scoreboard next state: a new load sets its rd, everything else counts down.
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            sb_d[i] = sb_q[i];
            if ((ld_a_s && (rd_a_s == 5'(i))) || (ld_b_s && (rd_b_s == 5'(i)))) begin
                sb_d[i] = SB_SET;
            end else if (sb_q[i] != '0) begin
                sb_d[i] = sb_q[i] - SBW'(1);
            end else begin
                sb_d[i] = sb_q[i];
            end
        end
    end

    // Branch-wait FSM and performance counter next state.
    always_comb begin
        state_d  = state_q;
        dual_d   = dual_q;
        single_d = single_q;
        case (state_q)
            RUN: begin
                if ((issue_a_s && is_cf(op_a_s)) || (issue_b_s && is_cf(op_b_s))) begin
                    state_d = WAIT_BR;
                end else begin
                    state_d = RUN;
                end
            end
            WAIT_BR: begin
                if (bus.br_resolved) begin
                    state_d = RUN;
                end else begin
                    state_d = WAIT_BR;
                end
            end
            default: state_d = RUN;
        endcase
        if (issue_a_s && issue_b_s) begin
            dual_d = dual_q + CNT_WIDTH'(1);
        end else if (issue_a_s) begin
            single_d = single_q + CNT_WIDTH'(1);
        end else begin
            dual_d = dual_q;
        end
    end

    // State registers with synchronous reset discarding all tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            dual_q   <= '0;
            single_q <= '0;
            for (int i = 1; i < 32; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            dual_q   <= dual_d;
            single_q <= single_d;
            for (int i = 1; i < 32; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end
endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Scoreboard bench for dual_issue_ctrl: expected issue decisions are queued with
// each stimulus cycle and popped for comparison before the next clock edge.
module tb_dual_issue_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   exp_dual;
    int   exp_single;

    typedef struct {
        string tag;
        logic  a;
        logic  b;
        logic  pc;
        logic  inc;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [31:0] ADDI_X1 = 32'h00100093;
    localparam logic [31:0] ADDI_X2 = 32'h00200113;
    localparam logic [31:0] ADDI_X1B = 32'h00300093;
    localparam logic [31:0] ADD_X3  = 32'h002081B3;
    localparam logic [31:0] LW_X5   = 32'h0000A283;
    localparam logic [31:0] ADD_X6  = 32'h00528333;
    localparam logic [31:0] BEQ     = 32'h00208463;
    localparam logic [31:0] SW_X6   = 32'h0060A023;

    dual_issue_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) ifc ();

    dual_issue_ctrl #(.DATA_WIDTH(32), .LOAD_LAT(3), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [31:0] a, input logic [31:0] b,
                        input logic st, input logic br,
                        input logic ea, input logic eb, input logic epc, input logic einc);
        exp_t e;
        rst             = r;
        ifc.InstrA      = a;
        ifc.InstrB      = b;
        ifc.stall_ext   = st;
        ifc.br_resolved = br;
        e = '{tag, ea, eb, epc, einc};
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq({e.tag, ".IssueA"},  {63'd0, ifc.IssueA},  {63'd0, e.a});
        check_eq({e.tag, ".IssueB"},  {63'd0, ifc.IssueB},  {63'd0, e.b});
        check_eq({e.tag, ".PCSrc"},   {63'd0, ifc.PCSrc},   {63'd0, e.pc});
        check_eq({e.tag, ".IncrSrc"}, {63'd0, ifc.IncrSrc}, {63'd0, e.inc});
        check_eq({e.tag, ".dual_cnt"},   {32'd0, ifc.dual_cnt},   64'(exp_dual));
        check_eq({e.tag, ".single_cnt"}, {32'd0, ifc.single_cnt}, 64'(exp_single));
        if (r) begin
            exp_dual   = 0;
            exp_single = 0;
        end else if (e.a && e.b) begin
            exp_dual++;
        end else if (e.a) begin
            exp_single++;
        end else begin
            exp_dual = exp_dual;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        checks = 0;
        failures = 0;
        exp_dual = 0;
        exp_single = 0;
        ifc.InstrA = 32'd0;
        ifc.InstrB = 32'd0;
        ifc.stall_ext = 1'b0;
        ifc.br_resolved = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("rst_hold",  1'b1, ADDI_X1, ADDI_X2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("indep",     1'b0, ADDI_X1, ADDI_X2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("raw_pair",  1'b0, ADDI_X1, ADD_X3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("waw_pair",  1'b0, ADDI_X1, ADDI_X1B,1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lw_issue",  1'b0, LW_X5,   ADD_X6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu_t1",     1'b0, ADD_X6,  ADDI_X2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("lu_t2",     1'b0, ADD_X6,  ADDI_X2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("lu_t3",     1'b0, ADD_X6,  ADDI_X2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("beq",       1'b0, BEQ,     ADDI_X2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("wait_br", 1'b0, ADDI_X1, ADDI_X2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        step("br_res",    1'b0, ADDI_X1, ADDI_X2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("resume",    1'b0, ADDI_X1, ADDI_X2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step("dual_mem",  1'b0, LW_X5,   SW_X6,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("stall",     1'b0, LW_X5,   SW_X6,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("post_st1",  1'b0, ADD_X6,  ADDI_X2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("post_st2",  1'b0, ADD_X6,  ADDI_X2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("lw_beq",    1'b0, LW_X5,   BEQ,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("rst_wait",  1'b1, ADD_X6,  ADDI_X2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("after_rst", 1'b0, ADD_X6,  ADDI_X2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("final",     1'b0, ADD_X6,  ADDI_X2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
